// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: button conditioning, count-tick prescaler and run/lap/pause FSM.
// Optional per-button debounce filter is enabled with `define STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  output logic       tick,
  output logic       sw_start,
  output logic       sw_stop,
  output logic       sw_clr,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DB_CYCLES < 1) begin : g_param_check
    $error("stopwatch_ctrl: TICK_DIV must be >= 2 and DB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  function automatic logic [PW-1:0] presc_next(input logic [PW-1:0] cnt);
    return (cnt == TICK_LAST) ? '0 : cnt + 1'b1;
  endfunction

  // Button bit order throughout: [2]=clr, [1]=lap, [0]=ss
  logic [2:0] btn_raw;
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;
  logic       vld_p0;
  logic       vld_p1;
  logic [2:0] lvl;
  logic [2:0] prev;
  logic [2:0] press;

  assign btn_raw = {btn_clr, btn_lap, btn_ss};

  // Stage p0/p1: two-flop synchronizer; vld marks when sync_p1 carries real button data
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [DBW-1:0] db_cnt [3];
  logic [2:0]     db_lvl;

  // Filtered level starts high so a button held through reset stays quiet
  always_ff @(posedge clk) begin
    if (reset) begin
      db_lvl <= '1;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else if (vld_p1) begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = db_lvl;
`else
  assign lvl = sync_p1;
`endif

  // Edge detect: prev is pinned high until the synchronizer has filled after reset
  always_ff @(posedge clk) begin
    if (reset) prev <= '1;
    else       prev <= vld_p1 ? lvl : 3'b111;
  end

  assign press = lvl & ~prev & {3{vld_p1}};

  logic ev_clr;
  logic ev_ss;
  logic ev_lap;

  assign ev_clr = press[2];
  assign ev_ss  = press[0] & ~press[2];
  assign ev_lap = press[1] & ~press[0] & ~press[2];

  state_t  st;
  state_t  nxt;
  logic    do_start;
  logic    do_stop;
  logic    do_clr;
  logic    do_cap;
  logic    run_en;
  logic [PW-1:0] presc;
  logic [5:0] lap_sec;
  logic [5:0] lap_min;

  always_comb begin
    nxt      = st;
    do_start = 1'b0;
    do_stop  = 1'b0;
    do_clr   = 1'b0;
    do_cap   = 1'b0;
    case (st)
      IDLE: begin
        if (ev_clr) begin
          do_clr = 1'b1;
        end else if (ev_ss) begin
          nxt      = RUN;
          do_start = 1'b1;
        end
      end
      RUN: begin
        if (ev_ss) begin
          nxt     = PAUSE;
          do_stop = 1'b1;
        end else if (ev_lap) begin
          nxt    = LAP;
          do_cap = 1'b1;
        end
      end
      LAP: begin
        if (ev_ss) begin
          nxt     = PAUSE;
          do_stop = 1'b1;
        end else if (ev_lap) begin
          nxt = RUN;
        end
      end
      PAUSE: begin
        if (ev_clr) begin
          nxt    = IDLE;
          do_clr = 1'b1;
        end else if (ev_ss) begin
          nxt      = RUN;
          do_start = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // A stop in this cycle already freezes the prescaler and suppresses its tick
  assign run_en = ((st == RUN) || (st == LAP)) && !do_stop;

  // Stage p2: registered state, command pulses, prescaler and display
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      sw_start <= 1'b0;
      sw_stop  <= 1'b0;
      sw_clr   <= 1'b0;
      tick     <= 1'b0;
      presc    <= '0;
      lap_sec  <= '0;
      lap_min  <= '0;
      disp_sec <= '0;
      disp_min <= '0;
    end else begin
      st       <= nxt;
      sw_start <= do_start;
      sw_stop  <= do_stop;
      sw_clr   <= do_clr;
      tick     <= run_en && (presc == TICK_LAST);

      if (do_clr)      presc <= '0;
      else if (run_en) presc <= presc_next(presc);

      if (do_cap) begin
        lap_sec <= sec;
        lap_min <= min;
      end

      if (do_cap) begin
        disp_sec <= sec;
        disp_min <= min;
      end else if (nxt == LAP) begin
        disp_sec <= lap_sec;
        disp_min <= lap_min;
      end else begin
        disp_sec <= sec;
        disp_min <= min;
      end
    end
  end

  assign state = st;

endmodule
